// File: rtl/data_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : data_mem_pkg
// Brief    : Shared types, width helpers and block addressing for the burst
//            data memory.
// Revision : 1.0 - initial release
// ============================================================================
package data_mem_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_WAIT  = 2'd1,
      S_BURST = 2'd2,
      S_ACK   = 2'd3
   } state_t;

   function automatic int unsigned beat_width(input int unsigned block_words);
      return $clog2(block_words);
   endfunction

   function automatic int unsigned cnt_width(input int unsigned latency);
      return $clog2(latency + 1);
   endfunction

   function automatic int unsigned idx_width(input int unsigned depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

   // Clears the in-block word offset so bursts wrap inside one cache block.
   function automatic logic [63:0] block_base(input logic [63:0] addr,
                                              input int unsigned beat_bits);
      return addr & ~((64'd1 << beat_bits) - 64'd1);
   endfunction

endpackage
`default_nettype wire

// File: rtl/data_mem_array.sv
`default_nettype none
// ============================================================================
// Module   : data_mem_array
// Brief    : DEPTH x WIDTH storage with byte-enable write port, combinational
//            read port and a word-0 debug tap.
// Revision : 1.0 - initial release
// ============================================================================
module data_mem_array #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned DEPTH = 1024,
   parameter int unsigned IDX_W = 10
) (
   input  logic               CLK,
   input  logic               RST,
   input  logic               i_we,
   input  logic [IDX_W-1:0]   i_widx,
   input  logic [WIDTH-1:0]   i_wdata,
   input  logic [WIDTH/8-1:0] i_be,
   input  logic [IDX_W-1:0]   i_ridx,
   output logic [WIDTH-1:0]   o_rdata,
   output logic [15:0]        o_tap
);

   logic [WIDTH-1:0] r_mem [DEPTH];

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            r_mem[i] <= '0;
         end
      end else if (i_we && (32'(i_widx) < DEPTH)) begin
         for (int b = 0; b < int'(WIDTH / 8); b++) begin
            if (i_be[b]) begin
               r_mem[i_widx][8*b +: 8] <= i_wdata[8*b +: 8];
            end
         end
      end
   end

   always_comb begin
      o_rdata = '0;
      if (32'(i_ridx) < DEPTH) begin
         o_rdata = r_mem[i_ridx];
      end
   end

   generate
      if (WIDTH >= 16) begin : g_tap_full
         assign o_tap = r_mem[0][15:0];
      end else begin : g_tap_narrow
         assign o_tap = 16'(r_mem[0]);
      end
   endgenerate

endmodule
`default_nettype wire

// File: rtl/data_memory_burst.sv
`default_nettype none
// ============================================================================
// Module   : data_memory_burst
// Brief    : Slow main memory with request handshake, configurable latency,
//            critical-word-first block reads and byte-enable word writes.
// Revision : 1.0 - initial release
// ============================================================================
module data_memory_burst
   import data_mem_pkg::*;
#(
   parameter int unsigned WIDTH       = 32,
   parameter int unsigned DEPTH       = 1024,
   parameter int unsigned BLOCK_WORDS = 4,
   parameter int unsigned LATENCY     = 4,
   parameter int unsigned ADDR_W      = 32
) (
   input  logic               CLK,
   input  logic               RST,
   input  logic               Req_Valid,
   output logic               Req_Ready,
   input  logic               Req_Write,
   input  logic [ADDR_W-1:0]  Req_Addr,
   input  logic [WIDTH-1:0]   Req_WData,
   input  logic [WIDTH/8-1:0] Req_BE,
   output logic               Rsp_Valid,
   output logic [WIDTH-1:0]   Rsp_RData,
   output logic               Rsp_Last,
   output logic               Rsp_Err,
   output logic [15:0]        Test_Value
);

   localparam int unsigned c_beat_w = beat_width(BLOCK_WORDS);
   localparam int unsigned c_cnt_w  = cnt_width(LATENCY);
   localparam int unsigned c_idx_w  = idx_width(DEPTH);

   state_t               r_state, w_state_nxt;
   logic [c_cnt_w-1:0]   r_cnt, w_cnt_nxt;
   logic [c_beat_w-1:0]  r_beat, w_beat_nxt, w_lo;
   logic                 r_write, w_write_nxt;
   logic [c_idx_w-1:0]   r_addr, w_addr_nxt, w_rd_idx;
   logic [WIDTH-1:0]     r_wdata, w_wdata_nxt, w_rd_data;
   logic [WIDTH/8-1:0]   r_be, w_be_nxt;
   logic                 r_err, w_err_nxt;
   logic                 r_rsp_valid, w_rsp_valid_nxt;
   logic [WIDTH-1:0]     r_rsp_rdata, w_rsp_rdata_nxt;
   logic                 r_rsp_last, w_rsp_last_nxt;
   logic                 r_rsp_err, w_rsp_err_nxt;
   logic                 w_we, w_issue;

   // Only the RAM index bits are kept; the range error is resolved at acceptance.
   assign w_lo     = r_addr[c_beat_w-1:0] + r_beat;
   assign w_rd_idx = c_idx_w'(block_base(64'(r_addr), c_beat_w)) | c_idx_w'(w_lo);

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_state     <= S_IDLE;
         r_cnt       <= '0;
         r_beat      <= '0;
         r_write     <= 1'b0;
         r_addr      <= '0;
         r_wdata     <= '0;
         r_be        <= '0;
         r_err       <= 1'b0;
         r_rsp_valid <= 1'b0;
         r_rsp_rdata <= '0;
         r_rsp_last  <= 1'b0;
         r_rsp_err   <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_cnt       <= w_cnt_nxt;
         r_beat      <= w_beat_nxt;
         r_write     <= w_write_nxt;
         r_addr      <= w_addr_nxt;
         r_wdata     <= w_wdata_nxt;
         r_be        <= w_be_nxt;
         r_err       <= w_err_nxt;
         r_rsp_valid <= w_rsp_valid_nxt;
         r_rsp_rdata <= w_rsp_rdata_nxt;
         r_rsp_last  <= w_rsp_last_nxt;
         r_rsp_err   <= w_rsp_err_nxt;
      end
   end

   always_comb begin
      w_state_nxt     = r_state;
      w_cnt_nxt       = r_cnt;
      w_beat_nxt      = r_beat;
      w_write_nxt     = r_write;
      w_addr_nxt      = r_addr;
      w_wdata_nxt     = r_wdata;
      w_be_nxt        = r_be;
      w_err_nxt       = r_err;
      w_rsp_valid_nxt = 1'b0;
      w_rsp_rdata_nxt = '0;
      w_rsp_last_nxt  = 1'b0;
      w_rsp_err_nxt   = 1'b0;
      w_we            = 1'b0;
      w_issue         = 1'b0;

      case (r_state)
         S_IDLE: begin
            if (Req_Valid) begin
               w_write_nxt = Req_Write;
               w_addr_nxt  = Req_Addr[c_idx_w-1:0];
               w_wdata_nxt = Req_WData;
               w_be_nxt    = Req_BE;
               w_err_nxt   = (64'(Req_Addr) >= 64'(DEPTH));
               w_cnt_nxt   = c_cnt_w'(LATENCY - 1);
               w_beat_nxt  = '0;
               w_state_nxt = S_WAIT;
            end
         end
         S_WAIT: begin
            if (r_cnt == '0) begin
               if (r_write) begin
                  w_we            = !r_err;
                  w_rsp_valid_nxt = 1'b1;
                  w_rsp_last_nxt  = 1'b1;
                  w_rsp_err_nxt   = r_err;
                  w_state_nxt     = S_ACK;
               end else begin
                  w_issue     = 1'b1;
                  w_state_nxt = S_BURST;
               end
            end else begin
               w_cnt_nxt = r_cnt - 1'b1;
            end
         end
         S_BURST: begin
            if (r_rsp_last) begin
               w_state_nxt = S_IDLE;
            end else begin
               w_issue = 1'b1;
            end
         end
         S_ACK: begin
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase

      // r_beat wraps back to 0 after the last beat, ready for the next burst.
      if (w_issue) begin
         w_rsp_valid_nxt = 1'b1;
         w_rsp_rdata_nxt = r_err ? '0 : w_rd_data;
         w_rsp_last_nxt  = (r_beat == c_beat_w'(BLOCK_WORDS - 1));
         w_rsp_err_nxt   = r_err;
         w_beat_nxt      = r_beat + 1'b1;
      end
   end

   data_mem_array #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .IDX_W (c_idx_w)
   ) u_array (
      .CLK     (CLK),
      .RST     (RST),
      .i_we    (w_we),
      .i_widx  (r_addr),
      .i_wdata (r_wdata),
      .i_be    (r_be),
      .i_ridx  (w_rd_idx),
      .o_rdata (w_rd_data),
      .o_tap   (Test_Value)
   );

   assign Req_Ready = (r_state == S_IDLE);
   assign Rsp_Valid = r_rsp_valid;
   assign Rsp_RData = r_rsp_rdata;
   assign Rsp_Last  = r_rsp_last;
   assign Rsp_Err   = r_rsp_err;

endmodule
`default_nettype wire

// File: tb/tb_data_memory_burst.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_memory_burst
// Brief    : Self-checking bench for data_memory_burst with a word-array model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_data_memory_burst;

   localparam int LAT = 4;
   localparam int BW  = 4;
   localparam int DEP = 1024;

   typedef struct {
      bit          wr;
      logic [31:0] addr;
      logic [31:0] wd;
      logic [3:0]  be;
      bit          poke;
      bit          chk_first;
      logic [31:0] exp_first;
      bit          exp_err;
   } vec_t;

   logic        CLK = 1'b0;
   logic        RST = 1'b0;
   logic        Req_Valid = 1'b0;
   logic        Req_Ready;
   logic        Req_Write = 1'b0;
   logic [31:0] Req_Addr = '0;
   logic [31:0] Req_WData = '0;
   logic [3:0]  Req_BE = '0;
   logic        Rsp_Valid;
   logic [31:0] Rsp_RData;
   logic        Rsp_Last;
   logic        Rsp_Err;
   logic [15:0] Test_Value;

   int n_checks = 0;
   int n_fail   = 0;
   logic [31:0] mem_model [DEP];

   data_memory_burst #(
      .WIDTH(32), .DEPTH(DEP), .BLOCK_WORDS(BW), .LATENCY(LAT), .ADDR_W(32)
   ) dut (
      .CLK(CLK), .RST(RST),
      .Req_Valid(Req_Valid), .Req_Ready(Req_Ready), .Req_Write(Req_Write),
      .Req_Addr(Req_Addr), .Req_WData(Req_WData), .Req_BE(Req_BE),
      .Rsp_Valid(Rsp_Valid), .Rsp_RData(Rsp_RData), .Rsp_Last(Rsp_Last),
      .Rsp_Err(Rsp_Err), .Test_Value(Test_Value)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic clear_model();
      for (int i = 0; i < DEP; i++) mem_model[i] = '0;
   endtask

   // One complete transaction: drive, measure latency, check every beat against the model.
   task automatic run_req(input vec_t v);
      int          lat;
      int          nb;
      bit          err;
      logic [31:0] exp;
      err = (v.addr >= DEP);
      check("ready_before", {31'd0, Req_Ready}, 32'd1);
      Req_Valid = 1'b1; Req_Write = v.wr; Req_Addr = v.addr; Req_WData = v.wd; Req_BE = v.be;
      tick();
      Req_Valid = 1'b0;
      lat = 0;
      while (Rsp_Valid !== 1'b1 && lat < 32) begin
         check("ready_busy", {31'd0, Req_Ready}, 32'd0);
         if (v.poke && lat == 1) begin
            Req_Valid = 1'b1; Req_Write = 1'b1; Req_WData = 32'h5A5A5A5A; Req_BE = 4'hF;
         end else begin
            Req_Valid = 1'b0;
         end
         tick();
         lat++;
      end
      Req_Valid = 1'b0;
      check("latency", lat, LAT);
      nb = v.wr ? 1 : BW;
      for (int k = 0; k < nb; k++) begin
         if (v.wr || err) exp = '0;
         else exp = mem_model[(v.addr & ~32'(BW - 1)) + ((v.addr + 32'(k)) % BW)];
         check("rsp_valid", {31'd0, Rsp_Valid}, 32'd1);
         check("rsp_rdata", Rsp_RData, exp);
         check("rsp_last", {31'd0, Rsp_Last}, (k == nb - 1) ? 32'd1 : 32'd0);
         check("rsp_err", {31'd0, Rsp_Err}, {31'd0, err});
         check("ready_rsp", {31'd0, Req_Ready}, 32'd0);
         if (k == 0 && v.chk_first) begin
            check("tbl_first", Rsp_RData, v.exp_first);
            check("tbl_err", {31'd0, Rsp_Err}, {31'd0, v.exp_err});
         end
         tick();
      end
      if (v.wr && !err) begin
         for (int b = 0; b < 4; b++)
            if (v.be[b]) mem_model[v.addr][8*b +: 8] = v.wd[8*b +: 8];
      end
      check("valid_after", {31'd0, Rsp_Valid}, 32'd0);
      check("ready_after", {31'd0, Req_Ready}, 32'd1);
      check("test_value", {16'd0, Test_Value}, {16'd0, mem_model[0][15:0]});
   endtask

   initial begin
      vec_t tbl [15];
      vec_t v;
      int   lat;

      tbl[0]  = '{0, 32'd7,    32'h0,        4'h0, 0, 1, 32'h0,        0};
      tbl[1]  = '{1, 32'd0,    32'hDEADBEEF, 4'hF, 0, 1, 32'h0,        0};
      tbl[2]  = '{1, 32'd5,    32'hAABBCCDD, 4'hF, 0, 1, 32'h0,        0};
      tbl[3]  = '{1, 32'd5,    32'h11223344, 4'h3, 0, 1, 32'h0,        0};
      tbl[4]  = '{0, 32'd5,    32'h0,        4'h0, 0, 1, 32'hAABB3344, 0};
      tbl[5]  = '{1, 32'd8,    32'h8,        4'hF, 0, 1, 32'h0,        0};
      tbl[6]  = '{1, 32'd9,    32'h9,        4'hF, 0, 1, 32'h0,        0};
      tbl[7]  = '{1, 32'd10,   32'hA,        4'hF, 0, 1, 32'h0,        0};
      tbl[8]  = '{1, 32'd11,   32'hB,        4'hF, 0, 1, 32'h0,        0};
      tbl[9]  = '{0, 32'd10,   32'h0,        4'h0, 1, 1, 32'hA,        0};
      tbl[10] = '{1, 32'd3,    32'h33,       4'hF, 0, 1, 32'h0,        0};
      tbl[11] = '{0, 32'd1024, 32'h0,        4'h0, 0, 1, 32'h0,        1};
      tbl[12] = '{1, 32'd1027, 32'hFFFFFFFF, 4'hF, 0, 1, 32'h0,        1};
      tbl[13] = '{0, 32'd3,    32'h0,        4'h0, 0, 1, 32'h33,       0};
      tbl[14] = '{0, 32'd0,    32'h0,        4'h0, 0, 1, 32'hDEADBEEF, 0};

      clear_model();
      #12;
      check("rst_ready", {31'd0, Req_Ready}, 32'd1);
      check("rst_valid", {31'd0, Rsp_Valid}, 32'd0);
      check("rst_test_value", {16'd0, Test_Value}, 32'd0);
      @(negedge CLK);
      RST = 1'b1;
      tick();
      check("post_rst_ready", {31'd0, Req_Ready}, 32'd1);

      foreach (tbl[i]) run_req(tbl[i]);

      // Read back the block that the ignored mid-wait write targeted.
      v = '{0, 32'd8, 32'h0, 4'h0, 0, 1, 32'h8, 0};
      run_req(v);

      for (int i = 0; i < 40; i++) begin
         v.wr        = 1'($urandom_range(0, 1));
         v.addr      = ($urandom_range(0, 9) == 0) ? 32'd1024 + 32'($urandom_range(0, 7))
                                                   : 32'($urandom_range(0, 15));
         v.wd        = $urandom;
         v.be        = 4'($urandom_range(0, 15));
         v.poke      = 1'($urandom_range(0, 1));
         v.chk_first = 1'b0;
         v.exp_first = '0;
         v.exp_err   = 1'b0;
         run_req(v);
      end

      // Asynchronous reset in the middle of the second beat of a burst.
      Req_Valid = 1'b1; Req_Write = 1'b0; Req_Addr = 32'd8;
      tick();
      Req_Valid = 1'b0;
      lat = 0;
      while (Rsp_Valid !== 1'b1 && lat < 32) begin
         tick();
         lat++;
      end
      tick();
      check("beat1_valid", {31'd0, Rsp_Valid}, 32'd1);
      #2 RST = 1'b0;
      #1;
      check("mid_rst_valid", {31'd0, Rsp_Valid}, 32'd0);
      check("mid_rst_last", {31'd0, Rsp_Last}, 32'd0);
      check("mid_rst_rdata", Rsp_RData, 32'd0);
      check("mid_rst_ready", {31'd0, Req_Ready}, 32'd1);
      check("mid_rst_test_value", {16'd0, Test_Value}, 32'd0);
      clear_model();
      @(negedge CLK);
      RST = 1'b1;
      tick();
      v = '{0, 32'd0, 32'h0, 4'h0, 0, 1, 32'h0, 0};
      run_req(v);
      v = '{0, 32'd10, 32'h0, 4'h0, 0, 1, 32'h0, 0};
      run_req(v);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
